// File: rtl/fbuf_write_scheduler.sv
// Framebuffer write-port scheduler: arbitrates the single BRAM write port
// between GPU single-pixel writes and an internal rectangle-fill engine.
// Round-robin on contention; all fbuf_* outputs are registered.
module fbuf_write_scheduler #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8,
  parameter int COORD_WIDTH         = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [FBUF_ADDR_WIDTH-1:0] pix_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] pix_data,
  input  logic                       fill_start,
  input  logic [COORD_WIDTH-1:0]     fill_x,
  input  logic [COORD_WIDTH-1:0]     fill_y,
  input  logic [COORD_WIDTH-1:0]     fill_w,
  input  logic [COORD_WIDTH-1:0]     fill_h,
  input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fill_err,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

  localparam logic [COORD_WIDTH:0]     W_LIM      = (COORD_WIDTH+1)'(FRAME_WIDTH_SCALED);
  localparam logic [COORD_WIDTH:0]     H_LIM      = (COORD_WIDTH+1)'(FRAME_HEIGHT_SCALED);
  localparam logic [FBUF_ADDR_WIDTH-1:0] ROW_STRIDE = FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);
  localparam logic [FBUF_ADDR_WIDTH-1:0] PIX_LIM    =
    FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED);
  localparam logic RR_PIX  = 1'b0;
  localparam logic RR_FILL = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_VALIDATE, S_FILL, S_DONE} state_t;

  state_t                     state, state_nx;
  logic                       rr_last;
  logic [COORD_WIDTH-1:0]     x_q, y_q, w_q, h_q, col_q, row_q;
  logic [FBUF_DATA_WIDTH-1:0] color_q;
  logic [FBUF_ADDR_WIDTH-1:0] row_base_q;
  logic [FBUF_ADDR_WIDTH-1:0] fill_addr;
  logic [COORD_WIDTH:0]       x_end, y_end;
  logic                       bounds_err, zero_size;
  logic                       fill_req, gnt_pix, gnt_fill;
  logic                       last_col, last_pix;

  // One extra bit on the edge sums so x+w / y+h can never wrap.
  assign x_end      = {1'b0, x_q} + {1'b0, w_q};
  assign y_end      = {1'b0, y_q} + {1'b0, h_q};
  assign bounds_err = (x_end > W_LIM) || (y_end > H_LIM);
  assign zero_size  = (w_q == '0) || (h_q == '0);

  assign fill_addr = row_base_q + FBUF_ADDR_WIDTH'(x_q) + FBUF_ADDR_WIDTH'(col_q);
  assign last_col  = (col_q == w_q - 1'b1);
  assign last_pix  = last_col && (row_q == h_q - 1'b1);

  // Arbitration: pixel side yields only when fill is waiting and pixel won last.
  assign fill_req  = (state == S_FILL);
  assign pix_ready = !rst && !(fill_req && (rr_last == RR_PIX));
  assign gnt_pix   = pix_valid && pix_ready;
  assign gnt_fill  = !rst && fill_req && !gnt_pix;
  assign fill_busy = (state != S_IDLE);

  // Fill FSM state register and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_last <= RR_FILL;
    end else begin
      state <= state_nx;
      if (gnt_pix)
        rr_last <= RR_PIX;
      else if (gnt_fill)
        rr_last <= RR_FILL;
    end
  end

  // Fill FSM next state and completion/error pulses.
  always_comb begin
    state_nx  = state;
    fill_done = 1'b0;
    fill_err  = 1'b0;
    case (state)
      S_IDLE:     if (fill_start) state_nx = S_VALIDATE;
      S_VALIDATE: begin
        if (bounds_err) begin
          fill_err = 1'b1;
          state_nx = S_IDLE;
        end else if (zero_size) begin
          fill_done = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          state_nx = S_FILL;
        end
      end
      S_FILL:     if (gnt_fill && last_pix) state_nx = S_DONE;
      S_DONE: begin
        fill_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  // Rectangle parameters and walk counters; row_base uses the single multiply
  // in VALIDATE and then steps by one row stride per completed row.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && fill_start) begin
      x_q     <= fill_x;
      y_q     <= fill_y;
      w_q     <= fill_w;
      h_q     <= fill_h;
      color_q <= fill_color;
    end
    if (state == S_VALIDATE) begin
      row_base_q <= FBUF_ADDR_WIDTH'(y_q) * ROW_STRIDE;
      col_q      <= '0;
      row_q      <= '0;
    end else if (gnt_fill) begin
      if (last_col) begin
        col_q      <= '0;
        row_q      <= row_q + 1'b1;
        row_base_q <= row_base_q + ROW_STRIDE;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Registered BRAM port: strobes for one cycle per grant, address/data hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fbuf_en_wr <= 1'b0;
      fbuf_wrea  <= 1'b0;
      fbuf_addr  <= '0;
      fbuf_data  <= '0;
    end else begin
      fbuf_en_wr <= 1'b0;
      fbuf_wrea  <= 1'b0;
      if (gnt_pix && (pix_addr < PIX_LIM)) begin
        fbuf_en_wr <= 1'b1;
        fbuf_wrea  <= 1'b1;
        fbuf_addr  <= pix_addr;
        fbuf_data  <= pix_data;
      end else if (gnt_fill) begin
        fbuf_en_wr <= 1'b1;
        fbuf_wrea  <= 1'b1;
        fbuf_addr  <= fill_addr;
        fbuf_data  <= color_q;
      end
    end
  end

endmodule

// File: tb/tb_fbuf_write_scheduler.sv
// Testbench for fbuf_write_scheduler: fixed rectangle table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_fbuf_write_scheduler;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [18:0] pix_addr = '0;
  logic [7:0]  pix_data = '0;
  logic        fill_start = 1'b0;
  logic [9:0]  fill_x = '0, fill_y = '0, fill_w = '0, fill_h = '0;
  logic [7:0]  fill_color = '0;
  logic        fill_busy, fill_done, fill_err;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  fbuf_write_scheduler dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_data(pix_data),
    .fill_start(fill_start), .fill_x(fill_x), .fill_y(fill_y), .fill_w(fill_w),
    .fill_h(fill_h), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [18:0] pa;
    logic [7:0]  pd;
    logic        fs;
    int          fx, fy, fw, fh;
    logic [7:0]  fc;
  } in_t;

  typedef struct {
    int x, y, w, h;
    int err, done, writes;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // reference model: rectangle expands to an address list, consumed one per fill grant
  int          q[$];
  bit          m_val, m_done;
  bit          rr_fill;
  int          mx, my, mw, mh;
  logic [7:0]  mc;
  logic        exp_en;
  logic [18:0] exp_addr;
  logic [7:0]  exp_data;

  // observations per sequence
  int obs_a[$];
  int obs_d[$];
  int obs_done, obs_err, obs_busy, wait_run, wait_max, pix_acc;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_val = 0; m_done = 0; rr_fill = 1;
    exp_en = 0; exp_addr = '0; exp_data = '0;
  endfunction

  function automatic void obs_clear();
    obs_a.delete(); obs_d.delete();
    obs_done = 0; obs_err = 0; obs_busy = 0; wait_run = 0; wait_max = 0; pix_acc = 0;
  endfunction

  function automatic in_t idle_in();
    in_t t;
    t.pv = 0; t.pa = '0; t.pd = '0; t.fs = 0;
    t.fx = 0; t.fy = 0; t.fw = 0; t.fh = 0; t.fc = '0;
    return t;
  endfunction

  function automatic in_t pix_in(int a, int d);
    in_t t = idle_in();
    t.pv = 1; t.pa = 19'(a); t.pd = 8'(d);
    return t;
  endfunction

  function automatic in_t fill_in(int x, int y, int w, int h, int c);
    in_t t = idle_in();
    t.fs = 1; t.fx = x; t.fy = y; t.fw = w; t.fh = h; t.fc = 8'(c);
    return t;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check combinational
  // outputs, then advance the model across the coming rising edge.
  task automatic step(input in_t t);
    bit busy, freq, ready, gp, gf, ok, zero, nv, nd;
    @(negedge clk);
    chk("fbuf_en_wr", fbuf_en_wr, exp_en);
    chk("fbuf_wrea", fbuf_wrea, exp_en);
    chk("fbuf_addr", fbuf_addr, exp_addr);
    chk("fbuf_data", fbuf_data, exp_data);
    if (fbuf_en_wr) begin
      obs_a.push_back(int'(fbuf_addr));
      obs_d.push_back(int'(fbuf_data));
    end
    pix_valid = t.pv; pix_addr = t.pa; pix_data = t.pd;
    fill_start = t.fs; fill_x = 10'(t.fx); fill_y = 10'(t.fy);
    fill_w = 10'(t.fw); fill_h = 10'(t.fh); fill_color = t.fc;
    #1;
    busy  = m_val || (q.size() > 0) || m_done;
    freq  = (q.size() > 0);
    ready = !(freq && !rr_fill);
    gp    = t.pv && ready;
    gf    = freq && !gp;
    ok    = (mx + mw <= W) && (my + mh <= H);
    zero  = (mw == 0) || (mh == 0);
    chk("pix_ready", pix_ready, ready);
    chk("fill_busy", fill_busy, busy);
    chk("fill_done", fill_done, m_done || (m_val && ok && zero));
    chk("fill_err", fill_err, m_val && !ok);
    obs_done += fill_done; obs_err += fill_err; obs_busy += fill_busy;
    if (t.pv && !pix_ready) wait_run++; else wait_run = 0;
    if (wait_run > wait_max) wait_max = wait_run;
    if (t.pv && pix_ready) pix_acc++;
    exp_en = 0;
    if (gp) begin
      rr_fill = 0;
      if (int'(t.pa) < W * H) begin
        exp_en = 1; exp_addr = t.pa; exp_data = t.pd;
      end
    end else if (gf) begin
      exp_en = 1; exp_addr = 19'(q.pop_front()); exp_data = mc; rr_fill = 1;
    end
    nd = gf && (q.size() == 0);
    nv = 0;
    if (m_val && ok && !zero)
      for (int r = 0; r < mh; r++)
        for (int c = 0; c < mw; c++)
          q.push_back((my + r) * W + mx + c);
    if (t.fs && !busy) begin
      nv = 1; mx = t.fx; my = t.fy; mw = t.fw; mh = t.fh; mc = t.fc;
    end
    m_val = nv; m_done = nd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(idle_in());
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_busy"}, fill_busy, 0);
    chk({tag, "_done"}, fill_done, 0);
    chk({tag, "_err"}, fill_err, 0);
    chk({tag, "_en_wr"}, fbuf_en_wr, 0);
    chk({tag, "_wrea"}, fbuf_wrea, 0);
    chk({tag, "_addr"}, fbuf_addr, 0);
    chk({tag, "_data"}, fbuf_data, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_valid = 1; fill_start = 0;
    #2 rst = 1;
    #1 check_outputs_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; pix_valid = 0;
    model_reset();
  endtask

  vec_t tbl[8];
  int   exp2[6];
  int   fill_w4, pix_w;
  in_t  t;

  initial begin
    tbl[0] = '{630, 0, 11, 1, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 5, 0, 1, 0};
    tbl[2] = '{630, 0, 10, 1, 0, 1, 10};
    tbl[3] = '{0, 479, 1, 2, 1, 0, 0};
    tbl[4] = '{639, 479, 1, 1, 0, 1, 1};
    tbl[5] = '{5, 5, 4, 3, 0, 1, 12};
    tbl[6] = '{1023, 1023, 1023, 1023, 1, 0, 0};
    tbl[7] = '{0, 0, 5, 0, 0, 1, 0};
    exp2 = '{1922, 1923, 1924, 2562, 2563, 2564};

    model_reset();
    mx = 0; my = 0; mw = 0; mh = 0; mc = '0;
    obs_clear();

    // reset state with a pending pixel request
    pix_valid = 1;
    #12 check_outputs_zero("rst_init");
    @(negedge clk);
    rst = 0; pix_valid = 0;

    // single pixel write
    obs_clear();
    step(pix_in('h12C05, 'hA5));
    chk("t1_ready", pix_ready, 1);
    idle(2);
    chk("t1_nwrites", obs_a.size(), 1);
    if (obs_a.size() >= 1) begin
      chk("t1_addr", obs_a[0], 'h12C05);
      chk("t1_data", obs_d[0], 'hA5);
    end

    // basic 3x2 fill
    obs_clear();
    step(fill_in(2, 3, 3, 2, 'h3C));
    idle(12);
    chk("t2_nwrites", obs_a.size(), 6);
    for (int i = 0; i < 6 && i < obs_a.size(); i++) begin
      chk("t2_addr", obs_a[i], exp2[i]);
      chk("t2_data", obs_d[i], 'h3C);
    end
    chk("t2_done", obs_done, 1);
    chk("t2_busy", obs_busy, 1 + 6 + 1);

    // bounds and degenerate rectangles
    for (int i = 0; i < 8; i++) begin
      obs_clear();
      step(fill_in(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, 'h50 + i));
      idle(16);
      chk("tbl_err", obs_err, tbl[i].err);
      chk("tbl_done", obs_done, tbl[i].done);
      chk("tbl_writes", obs_a.size(), tbl[i].writes);
    end

    // contention: 4-pixel fill against continuous pixel traffic
    obs_clear();
    t = fill_in(0, 0, 4, 1, 'h77);
    t.pv = 1; t.pa = 19'(1000); t.pd = 8'h01;
    step(t);
    for (int i = 0; i < 12; i++) step(pix_in(1000 + pix_acc, 1));
    idle(3);
    fill_w4 = 0; pix_w = 0;
    foreach (obs_a[i]) begin
      if (obs_a[i] < 4) fill_w4++;
      else pix_w++;
    end
    chk("t4_fill_writes", fill_w4, 4);
    chk("t4_pix_writes", pix_w, pix_acc);
    chk("t4_max_wait", wait_max, 1);
    chk("t4_done", obs_done, 1);

    // dropped out-of-range pixel
    obs_clear();
    step(pix_in(W * H, 'hEE));
    chk("t5_drop_ready", pix_ready, 1);
    idle(2);
    chk("t5_drop_writes", obs_a.size(), 0);

    // fill_start during FILL is ignored
    obs_clear();
    step(fill_in(10, 10, 3, 1, 'h99));
    idle(1);
    step(fill_in(0, 0, 2, 2, 'h11));
    idle(6);
    chk("t5_nwrites", obs_a.size(), 3);
    for (int i = 0; i < 3 && i < obs_a.size(); i++)
      chk("t5_addr", obs_a[i], 6410 + i);
    chk("t5_done", obs_done, 1);

    // reset in the middle of row 1
    step(fill_in(0, 0, 4, 3, 'h42));
    idle(6);
    do_reset();
    obs_clear();
    chk("t6_busy_after", fill_busy, 0);
    step(pix_in(55, 'h11));
    chk("t6_ready", pix_ready, 1);
    idle(2);
    chk("t6_nwrites", obs_a.size(), 1);
    if (obs_a.size() >= 1) chk("t6_addr", obs_a[0], 55);
    chk("t6_no_done", obs_done, 0);

    // randomized traffic against the model
    obs_clear();
    for (int i = 0; i < 3000; i++) begin
      t = idle_in();
      t.pv = ($urandom_range(0, 1) == 1);
      t.pa = ($urandom_range(0, 7) == 0) ? 19'(W * H + $urandom_range(0, 2000))
                                         : 19'($urandom_range(0, W * H - 1));
      t.pd = 8'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        t.fs = 1;
        t.fx = $urandom_range(0, 639);
        t.fy = $urandom_range(0, 479);
        t.fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 12);
        t.fh = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 5);
        t.fc = 8'($urandom);
      end
      step(t);
    end
    idle(80);
    chk("rand_max_wait_le1", (wait_max <= 1) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
